// File: rtl/uart_tx_fifo_if_if.sv
// Interface between the TX FIFO (master side) and the UART transmitter (slave side).
// The FIFO side provides the first-word-fall-through head word and its empty flag.
// The transmitter side returns the pop strobe, the serial line and the frame status.
interface uart_tx_fifo_if_if #(
  parameter int DBIT = 8
);
  logic            tx_empty;
  logic [DBIT-1:0] tx_data;
  logic            tx_rd;
  logic            o_tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_empty, tx_data,
    input  tx_rd, o_tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_empty, tx_data,
    output tx_rd, o_tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_fifo_if.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Frame: start bit, DBIT data bits LSB first, stop of SB_TICK oversample ticks.
// Every bit lasts 16 oversample ticks, and each tick lasts BAUD_DVSR clk.
// The baud counter is held in IDLE so that each frame starts phase-aligned.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit between the data and the stop bit.
module uart_tx_fifo_if #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int BAUD_DVSR = 163
) (
  input logic          clk,
  input logic          reset_n,
  uart_tx_fifo_if_if.slave tx_if
);

  localparam int CW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(BAUD_DVSR - 1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            s_tick;
  logic            rd;
  logic            done;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  // Oversample tick: only meaningful while a frame is in flight.
  assign s_tick = (state_q != IDLE) && (cnt_q == CNT_LAST);

  // Baud counter: free-runs 0..BAUD_DVSR-1 during a frame, parked at 0 in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Frame state, tick/bit counters, shift register and the registered line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic; pop strobe and done tick are decoded from the current state.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    rd      = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // The FIFO head is popped the very clk it becomes available.
        rd = reset_n & ~tx_if.tx_empty;
        if (rd) begin
          b_d     = tx_if.tx_data;
          s_d     = '0;
          state_d = START;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_if.tx_data;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_d  = n_q + 1'b1;
              tx_d = b_d[0];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_if.tx_rd        = rd;
  assign tx_if.o_tx         = tx_q;
  assign tx_if.tx_busy      = (state_q != IDLE);
  assign tx_if.tx_done_tick = done;

endmodule
